// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: row layout, physical register and data word.
// Package name Types is kept because other blocks import it under that name.
package Types;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;
    localparam int P_REG_W   = 6;
    localparam int WORD_W    = 32;

    typedef logic [P_REG_W-1:0] p_reg;
    typedef logic [WORD_W-1:0]  word;

    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic [ROB_IDX_W-1:0] rob_num;
        logic                 reg_write;
        logic [4:0]           arch_dst;
        p_reg                 preg_dst;
        p_reg                 old_preg_dst;
        word                  data;
    } rob_row_struct;

    // p0 is the hard-wired zero register and never goes back to the free list
    function automatic logic frees_preg(rob_row_struct r);
        return r.reg_write && (r.old_preg_dst != '0);
    endfunction

endpackage

// File: rtl/reorder_buffer_cmpl_sel.sv
// Per-slot completion select: for every ROB slot, pick the lowest-numbered
// completion port that targets it.
module rob_cmpl_sel
    import Types::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int CMPL_W = 3
) (
    input  logic                 cmpl_valid [0:CMPL_W-1],
    input  logic [ROB_IDX_W-1:0] cmpl_rob   [0:CMPL_W-1],
    input  word                  cmpl_data  [0:CMPL_W-1],
    output logic                 hit        [0:DEPTH-1],
    output word                  hit_data   [0:DEPTH-1]
);

    // Scanning from the highest port down lets the lowest port overwrite last.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            hit[s]      = 1'b0;
            hit_data[s] = '0;
            for (int k = CMPL_W - 1; k >= 0; k--) begin
                if (cmpl_valid[k] && (cmpl_rob[k] == ROB_IDX_W'(s))) begin
                    hit[s]      = 1'b1;
                    hit_data[s] = cmpl_data[k];
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: two-wide allocate by ROBNumber, multi-port completion, two-wide in-order retire.
// Define REORDER_BUFFER_STATS_EN to add the o_retired_total counter port.
module reorder_buffer
    import Types::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int CMPL_W = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  rob_row_struct        i_rob_rows        [0:1],
    input  logic                 i_cmpl_valid      [0:CMPL_W-1],
    input  logic [ROB_IDX_W-1:0] i_cmpl_rob        [0:CMPL_W-1],
    input  word                  i_cmpl_data       [0:CMPL_W-1],
    output logic                 o_retire_valid    [0:1],
    output rob_row_struct        o_retire_row      [0:1],
    output logic                 o_free_preg_valid [0:1],
    output p_reg                 o_free_preg       [0:1],
    output logic [ROB_IDX_W:0]   o_count,
    output logic                 o_full,
    output logic                 o_alloc_err
`ifdef REORDER_BUFFER_STATS_EN
    ,
    output logic [31:0]          o_retired_total
`endif
);

    localparam int CNT_W = ROB_IDX_W + 1;

    rob_row_struct        ent     [0:DEPTH-1];
    rob_row_struct        ent_nxt [0:DEPTH-1];
    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] head_p1;
    logic                 ret0;
    logic                 ret1;
    logic                 wr0;
    logic                 wr1;
    logic                 same_idx;
    logic                 err_now;
    logic [1:0]           n_alloc;
    logic [1:0]           n_ret;
    logic                 hit      [0:DEPTH-1];
    word                  hit_data [0:DEPTH-1];

    rob_cmpl_sel #(
        .DEPTH  (DEPTH),
        .CMPL_W (CMPL_W)
    ) u_cmpl_sel (
        .cmpl_valid (i_cmpl_valid),
        .cmpl_rob   (i_cmpl_rob),
        .cmpl_data  (i_cmpl_data),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    always_comb begin
        head_p1  = head + 1'b1;
        ret0     = ent[head].valid && ent[head].complete;
        ret1     = ret0 && ent[head_p1].valid && ent[head_p1].complete;
        same_idx = (i_rob_rows[1].rob_num == i_rob_rows[0].rob_num);
        wr0      = i_rob_rows[0].valid && !ent[i_rob_rows[0].rob_num].valid;
        wr1      = i_rob_rows[1].valid && !ent[i_rob_rows[1].rob_num].valid
                   && !(i_rob_rows[0].valid && same_idx);
        err_now  = (i_rob_rows[0].valid && !wr0) || (i_rob_rows[1].valid && !wr1);
        n_alloc  = {1'b0, wr0} + {1'b0, wr1};
        n_ret    = {1'b0, ret0} + {1'b0, ret1};

        // Completions only land on slots already valid in registered state,
        // so a slot allocated this cycle cannot be completed by it.
        for (int s = 0; s < DEPTH; s++) begin
            ent_nxt[s] = ent[s];
            if (ent[s].valid && hit[s]) begin
                ent_nxt[s].complete = 1'b1;
                ent_nxt[s].data     = hit_data[s];
            end
        end
        if (wr0) begin
            ent_nxt[i_rob_rows[0].rob_num]          = i_rob_rows[0];
            ent_nxt[i_rob_rows[0].rob_num].valid    = 1'b1;
            ent_nxt[i_rob_rows[0].rob_num].complete = 1'b0;
        end
        if (wr1) begin
            ent_nxt[i_rob_rows[1].rob_num]          = i_rob_rows[1];
            ent_nxt[i_rob_rows[1].rob_num].valid    = 1'b1;
            ent_nxt[i_rob_rows[1].rob_num].complete = 1'b0;
        end
        if (ret0) begin
            ent_nxt[head].valid    = 1'b0;
            ent_nxt[head].complete = 1'b0;
        end
        if (ret1) begin
            ent_nxt[head_p1].valid    = 1'b0;
            ent_nxt[head_p1].complete = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                ent[s] <= '0;
            end
            head        <= '0;
            o_count     <= '0;
            o_alloc_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                o_retire_valid[i]    <= 1'b0;
                o_retire_row[i]      <= '0;
                o_free_preg_valid[i] <= 1'b0;
                o_free_preg[i]       <= '0;
            end
        end else begin
            ent         <= ent_nxt;
            head        <= head + ROB_IDX_W'(n_ret);
            o_count     <= o_count + CNT_W'(n_alloc) - CNT_W'(n_ret);
            o_alloc_err <= o_alloc_err | err_now;

            o_retire_valid[0]    <= ret0;
            o_retire_row[0]      <= ret0 ? ent[head] : '0;
            o_free_preg_valid[0] <= ret0 && frees_preg(ent[head]);
            o_free_preg[0]       <= (ret0 && frees_preg(ent[head])) ? ent[head].old_preg_dst : '0;

            o_retire_valid[1]    <= ret1;
            o_retire_row[1]      <= ret1 ? ent[head_p1] : '0;
            o_free_preg_valid[1] <= ret1 && frees_preg(ent[head_p1]);
            o_free_preg[1]       <= (ret1 && frees_preg(ent[head_p1])) ? ent[head_p1].old_preg_dst : '0;
        end
    end

    assign o_full = (o_count == CNT_W'(DEPTH));

`ifdef REORDER_BUFFER_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_retired_total <= '0;
        end else begin
            o_retired_total <= o_retired_total + 32'(n_ret);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, corner sequences
// and random traffic against an in-order commit model.
module tb_reorder_buffer;
    import Types::*;

    localparam int CW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    rob_row_struct i_rob_rows        [0:1];
    logic          i_cmpl_valid      [0:CW-1];
    logic [3:0]    i_cmpl_rob        [0:CW-1];
    word           i_cmpl_data       [0:CW-1];
    logic          o_retire_valid    [0:1];
    rob_row_struct o_retire_row      [0:1];
    logic          o_free_preg_valid [0:1];
    p_reg          o_free_preg       [0:1];
    logic [4:0]    o_count;
    logic          o_full;
    logic          o_alloc_err;
`ifdef REORDER_BUFFER_STATS_EN
    logic [31:0]   o_retired_total;
`endif

    reorder_buffer #(.DEPTH(16), .CMPL_W(CW)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_rob_rows        (i_rob_rows),
        .i_cmpl_valid      (i_cmpl_valid),
        .i_cmpl_rob        (i_cmpl_rob),
        .i_cmpl_data       (i_cmpl_data),
        .o_retire_valid    (o_retire_valid),
        .o_retire_row      (o_retire_row),
        .o_free_preg_valid (o_free_preg_valid),
        .o_free_preg       (o_free_preg),
        .o_count           (o_count),
        .o_full            (o_full),
        .o_alloc_err       (o_alloc_err)
`ifdef REORDER_BUFFER_STATS_EN
        ,
        .o_retired_total   (o_retired_total)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: slots keyed by ROBNumber, commit walks forward from head.
    rob_row_struct m_ent [16];
    int            m_head;
    int            m_count;
    bit            m_err;
    logic [31:0]   m_total;
    bit            e_rv [2];
    rob_row_struct e_row [2];
    bit            e_fv [2];
    p_reg          e_fp [2];

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) m_ent[s] = '0;
        m_head = 0; m_count = 0; m_err = 0; m_total = 0;
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = 0; e_row[i] = '0; e_fv[i] = 0; e_fp[i] = '0;
        end
    endfunction

    function automatic void model_step();
        rob_row_struct old [16];
        bit            taken [16];
        int            nret;
        int            r0;
        int            r1;
        bit            w0;
        bit            w1;
        old  = m_ent;
        nret = 0;
        for (int s = 0; s < 16; s++) taken[s] = 0;
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (m_head + k) % 16;
            e_rv[k] = 0; e_row[k] = '0; e_fv[k] = 0; e_fp[k] = '0;
            if (nret == k && old[idx].valid && old[idx].complete) begin
                e_rv[k]  = 1;
                e_row[k] = old[idx];
                e_fv[k]  = old[idx].reg_write && (old[idx].old_preg_dst != 0);
                e_fp[k]  = e_fv[k] ? old[idx].old_preg_dst : '0;
                nret++;
            end
        end
        for (int k = 0; k < CW; k++) begin
            int r;
            r = int'(i_cmpl_rob[k]);
            if (i_cmpl_valid[k] && old[r].valid && !taken[r]) begin
                taken[r] = 1;
                m_ent[r].complete = 1;
                m_ent[r].data = i_cmpl_data[k];
            end
        end
        r0 = int'(i_rob_rows[0].rob_num);
        r1 = int'(i_rob_rows[1].rob_num);
        w0 = i_rob_rows[0].valid && !old[r0].valid;
        w1 = i_rob_rows[1].valid && !old[r1].valid && !(i_rob_rows[0].valid && r0 == r1);
        if (i_rob_rows[0].valid && !w0) m_err = 1;
        if (i_rob_rows[1].valid && !w1) m_err = 1;
        if (w0) begin
            m_ent[r0] = i_rob_rows[0]; m_ent[r0].valid = 1; m_ent[r0].complete = 0;
        end
        if (w1) begin
            m_ent[r1] = i_rob_rows[1]; m_ent[r1].valid = 1; m_ent[r1].complete = 0;
        end
        for (int k = 0; k < nret; k++) begin
            m_ent[(m_head + k) % 16].valid = 0;
            m_ent[(m_head + k) % 16].complete = 0;
        end
        m_head  = (m_head + nret) % 16;
        m_count = m_count + int'(w0) + int'(w1) - nret;
        m_total = m_total + 32'(nret);
    endfunction

    task automatic compare_all(string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.rv%0d", tag, i), 64'(o_retire_valid[i]), 64'(e_rv[i]));
            check($sformatf("%s.row%0d", tag, i), {8'b0, o_retire_row[i]}, {8'b0, e_row[i]});
            check($sformatf("%s.fv%0d", tag, i), 64'(o_free_preg_valid[i]), 64'(e_fv[i]));
            check($sformatf("%s.fp%0d", tag, i), 64'(o_free_preg[i]), 64'(e_fp[i]));
        end
        check($sformatf("%s.count", tag), 64'(o_count), 64'(m_count));
        check($sformatf("%s.full", tag), 64'(o_full), 64'(m_count == 16));
        check($sformatf("%s.err", tag), 64'(o_alloc_err), 64'(m_err));
`ifdef REORDER_BUFFER_STATS_EN
        check($sformatf("%s.total", tag), 64'(o_retired_total), 64'(m_total));
`endif
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) i_rob_rows[i] = '0;
        for (int k = 0; k < CW; k++) begin
            i_cmpl_valid[k] = 1'b0; i_cmpl_rob[k] = '0; i_cmpl_data[k] = '0;
        end
    endtask

    task automatic set_row(int i, bit v, int rob, bit rw, int old);
        i_rob_rows[i]              = '0;
        i_rob_rows[i].valid        = v;
        i_rob_rows[i].rob_num      = 4'(rob);
        i_rob_rows[i].reg_write    = rw;
        i_rob_rows[i].arch_dst     = 5'(rob + 3);
        i_rob_rows[i].preg_dst     = 6'(rob + 32);
        i_rob_rows[i].old_preg_dst = 6'(old);
        i_rob_rows[i].data         = 32'hF000 + 32'(rob);
    endtask

    task automatic set_cmpl(int k, int rob, word d);
        i_cmpl_valid[k] = 1'b1; i_cmpl_rob[k] = 4'(rob); i_cmpl_data[k] = d;
    endtask

    task automatic cycle(string tag);
        model_step();
        @(posedge i_clk);
        #1;
        compare_all(tag);
    endtask

    task automatic pulse_reset(string tag);
        i_rst = 1'b1;
        #2;
        model_reset();
        compare_all(tag);
        i_rst = 1'b0;
    endtask

    typedef struct packed {
        logic a0v; logic [3:0] a0r; logic a0w; logic [5:0] a0o;
        logic a1v; logic [3:0] a1r; logic a1w; logic [5:0] a1o;
        logic [2:0] cv; logic [3:0] cr0; logic [3:0] cr1; logic [3:0] cr2;
        word cd0; word cd1; word cd2;
        logic [1:0] erv; word ed0; word ed1; logic [1:0] efv;
        logic [5:0] efp0; logic [5:0] efp1; logic [4:0] ecnt; logic eerr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        bit seen;
        // a0v a0r a0w a0o | a1v a1r a1w a1o | cv cr0 cr1 cr2 cd0 cd1 cd2 | erv ed0 ed1 efv efp0 efp1 ecnt eerr
        vecs[0]  = '{1,0,0,0, 1,1,0,0,  3'b000,0,0,0, 0,0,0,             2'b00,0,0,0,0,0,2,0};
        vecs[1]  = '{0,0,0,0, 0,0,0,0,  3'b001,1,0,0, 32'h1111,0,0,      2'b00,0,0,0,0,0,2,0};
        vecs[2]  = '{0,0,0,0, 0,0,0,0,  3'b001,0,0,0, 32'h0AAA,0,0,      2'b00,0,0,0,0,0,2,0};
        vecs[3]  = '{0,0,0,0, 0,0,0,0,  3'b000,0,0,0, 0,0,0,             2'b11,32'h0AAA,32'h1111,0,0,0,0,0};
        vecs[4]  = '{1,2,1,0, 1,3,1,17, 3'b000,0,0,0, 0,0,0,             2'b00,0,0,0,0,0,2,0};
        vecs[5]  = '{0,0,0,0, 0,0,0,0,  3'b011,2,3,0, 32'h22,32'hDEADBEEF,0, 2'b00,0,0,0,0,0,2,0};
        vecs[6]  = '{0,0,0,0, 0,0,0,0,  3'b000,0,0,0, 0,0,0,             2'b11,32'h22,32'hDEADBEEF,2'b10,0,17,0,0};
        vecs[7]  = '{1,4,1,5, 0,0,0,0,  3'b000,0,0,0, 0,0,0,             2'b00,0,0,0,0,0,1,0};
        vecs[8]  = '{0,0,0,0, 0,0,0,0,  3'b111,4,9,4, 32'h11,32'h99,32'h22, 2'b00,0,0,0,0,0,1,0};
        vecs[9]  = '{0,0,0,0, 0,0,0,0,  3'b000,0,0,0, 0,0,0,             2'b01,32'h11,0,2'b01,5,0,0,0};
        vecs[10] = '{1,5,0,0, 1,5,1,7,  3'b000,0,0,0, 0,0,0,             2'b00,0,0,0,0,0,1,1};
        vecs[11] = '{0,0,0,0, 0,0,0,0,  3'b001,5,0,0, 32'h55,0,0,        2'b00,0,0,0,0,0,1,1};
        vecs[12] = '{0,0,0,0, 0,0,0,0,  3'b000,0,0,0, 0,0,0,             2'b01,32'h55,0,0,0,0,0,1};

        idle_inputs();
        i_rst = 1'b0;
        #1;
        pulse_reset("reset");

        // Directed table: dual alloc/retire, free-preg rules, completion priority, alloc error
        for (int n = 0; n < 13; n++) begin
            idle_inputs();
            set_row(0, vecs[n].a0v, int'(vecs[n].a0r), vecs[n].a0w, int'(vecs[n].a0o));
            set_row(1, vecs[n].a1v, int'(vecs[n].a1r), vecs[n].a1w, int'(vecs[n].a1o));
            if (vecs[n].cv[0]) set_cmpl(0, int'(vecs[n].cr0), vecs[n].cd0);
            if (vecs[n].cv[1]) set_cmpl(1, int'(vecs[n].cr1), vecs[n].cd1);
            if (vecs[n].cv[2]) set_cmpl(2, int'(vecs[n].cr2), vecs[n].cd2);
            cycle($sformatf("vec%0d", n));
            check($sformatf("vec%0d.t_rv", n), {62'b0, o_retire_valid[1], o_retire_valid[0]}, 64'(vecs[n].erv));
            check($sformatf("vec%0d.t_d0", n), 64'(o_retire_row[0].data), 64'(vecs[n].ed0));
            check($sformatf("vec%0d.t_d1", n), 64'(o_retire_row[1].data), 64'(vecs[n].ed1));
            check($sformatf("vec%0d.t_fv", n), {62'b0, o_free_preg_valid[1], o_free_preg_valid[0]}, 64'(vecs[n].efv));
            check($sformatf("vec%0d.t_fp0", n), 64'(o_free_preg[0]), 64'(vecs[n].efp0));
            check($sformatf("vec%0d.t_fp1", n), 64'(o_free_preg[1]), 64'(vecs[n].efp1));
            check($sformatf("vec%0d.t_cnt", n), 64'(o_count), 64'(vecs[n].ecnt));
            check($sformatf("vec%0d.t_err", n), 64'(o_alloc_err), 64'(vecs[n].eerr));
        end

        // Fill all 16 slots, then hit an occupied slot
        idle_inputs();
        pulse_reset("fill_rst");
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            set_row(0, 1, 2 * c, 1, 2 * c + 1);
            set_row(1, 1, 2 * c + 1, 0, 0);
            cycle("fill");
        end
        check("fill.count16", 64'(o_count), 64'd16);
        check("fill.full", 64'(o_full), 64'd1);
        idle_inputs();
        set_row(0, 1, 5, 1, 44);
        cycle("fill_occ");
        check("fill_occ.err", 64'(o_alloc_err), 64'd1);
        check("fill_occ.count", 64'(o_count), 64'd16);
        idle_inputs();
        cycle("fill_hold");
        check("fill_hold.err", 64'(o_alloc_err), 64'd1);

        // Drain 0..14 so head parks at 15, then retire 15 and 0 together
        for (int b = 0; b < 15; b += 3) begin
            idle_inputs();
            for (int k = 0; k < 3; k++) set_cmpl(k, b + k, 32'h100 + 32'(b + k));
            cycle("wrap_cmpl");
        end
        idle_inputs();
        for (int c = 0; c < 12; c++) cycle("wrap_drain");
        check("wrap.count1", 64'(o_count), 64'd1);
        set_row(0, 1, 0, 1, 9);
        cycle("wrap_alloc0");
        idle_inputs();
        set_cmpl(0, 15, 32'hF15);
        set_cmpl(1, 0, 32'hF00);
        cycle("wrap_cmpl2");
        idle_inputs();
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            cycle("wrap_wait");
            if (o_retire_valid[0]) seen = 1;
        end
        check("wrap.seen", 64'(seen), 64'd1);
        check("wrap.both", 64'(o_retire_valid[1]), 64'd1);
        check("wrap.rob15", 64'(o_retire_row[0].rob_num), 64'd15);
        check("wrap.rob0", 64'(o_retire_row[1].rob_num), 64'd0);
        set_row(0, 1, 1, 0, 0);
        cycle("wrap_alloc1");
        idle_inputs();
        set_cmpl(2, 1, 32'hABC);
        cycle("wrap_cmpl1");
        idle_inputs();
        cycle("wrap_ret1");
        check("wrap.head1_rv", 64'(o_retire_valid[0]), 64'd1);
        check("wrap.head1_rob", 64'(o_retire_row[0].rob_num), 64'd1);

        // Reset between completion and retire edge
        idle_inputs();
        pulse_reset("mid_rst0");
        set_row(0, 1, 0, 1, 12);
        cycle("mid_alloc");
        idle_inputs();
        set_cmpl(0, 0, 32'h77);
        cycle("mid_cmpl");
        idle_inputs();
        pulse_reset("mid_rst");
        for (int c = 0; c < 3; c++) begin
            cycle("mid_after");
            check("mid_after.no_rv", 64'(o_retire_valid[0]), 64'd0);
            check("mid_after.cnt0", 64'(o_count), 64'd0);
        end

        // Random traffic against the model
        pulse_reset("rand_rst");
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(99) < 60) begin
                    int rob;
                    int old;
                    rob = ($urandom_range(99) < 75) ? (m_head + m_count + i) % 16 : int'($urandom_range(15));
                    old = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(63));
                    set_row(i, 1, rob, 1'($urandom_range(1)), old);
                end
            end
            for (int k = 0; k < CW; k++) begin
                if ($urandom_range(1) == 1)
                    set_cmpl(k, (m_head + int'($urandom_range(5))) % 16, $urandom);
            end
            cycle("rand");
            if ($urandom_range(299) == 0) begin
                idle_inputs();
                pulse_reset("rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
